// File: rtl/branch_cmp_unit_if.sv
// -----------------------------------------------------------------------------
// branch_cmp_unit_if
//   Request/response bundle between the branch issue logic (master) and the
//   iterative branch comparator (slave).
//
//   Request side : req_valid, req_ready, rs1, rs2, funct3, pc, imm, flush
//   Response side: resp_valid, resp_ready, taken, target, illegal
//
//   rs1/rs2 use an ascending range: bit 0 is the MSB, so chunk i occupies
//   bits [i*CHUNK : i*CHUNK+CHUNK-1] and chunk 0 is the most significant.
// -----------------------------------------------------------------------------
interface branch_cmp_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [0:XLEN-1] rs1;
  logic [0:XLEN-1] rs2;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic            taken;
  logic [XLEN-1:0] target;
  logic            illegal;

  modport master (
    output req_valid, rs1, rs2, funct3, pc, imm, flush, resp_ready,
    input  req_ready, resp_valid, taken, target, illegal
  );

  modport slave (
    input  req_valid, rs1, rs2, funct3, pc, imm, flush, resp_ready,
    output req_ready, resp_valid, taken, target, illegal
  );
endinterface

// File: rtl/branch_cmp_unit.sv
// -----------------------------------------------------------------------------
// branch_cmp_unit
//   Iterative branch-condition resolver. Compares rs1/rs2 CHUNK bits per cycle,
//   most significant chunk first, and returns taken/target/illegal over a
//   valid/ready handshake. Only one transaction is in flight at a time.
//
// Ports
//   clk    : clock, all state updates on posedge
//   rst_n  : synchronous active-low reset
//   bus    : branch_cmp_unit_if.slave (request, flush, response)
//
// Parameters
//   XLEN   : operand/address width
//   CHUNK  : bits compared per cycle; XLEN must be a multiple of CHUNK
//
// Configuration macro
//   BRANCH_CMP_EARLY_EXIT_EN : defined   -> leave CMP on the first differing
//                                           chunk (latency 2..N+1)
//                              undefined -> always walk all N chunks
//                                           (fixed latency N+1)
//   Results are identical in both builds.
// -----------------------------------------------------------------------------
module branch_cmp_unit #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_cmp_unit_if.slave bus
);

  localparam int N  = XLEN / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (XLEN % CHUNK != 0) begin : g_bad_chunk
    $error("branch_cmp_unit: XLEN must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [0:XLEN-1] rs1_q, rs1_d;
  logic [0:XLEN-1] rs2_q, rs2_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            lt_q, lt_d;
  logic            eq_q, eq_d;
  logic            diff_q, diff_d;   // a differing chunk has already been seen
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;

  logic [0:CHUNK-1] a_chunk, b_chunk;
  logic             chunk_ne, chunk_lt;
  logic             last_chunk, done_now;

  // Branch outcome from the final ordering flags.
  function automatic logic resolve(input logic [2:0] f3, input logic lt,
                                   input logic eq);
    case (f3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100,
      3'b110:  return lt;
      3'b101,
      3'b111:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

  // Current chunk. For signed compares the sign bit (bit 0, only present in
  // chunk 0) is inverted on both operands so an unsigned compare of the
  // chunks yields the signed ordering.
  always_comb begin
    a_chunk = rs1_q[int'(idx_q) * CHUNK +: CHUNK];
    b_chunk = rs2_q[int'(idx_q) * CHUNK +: CHUNK];
    if ((f3_q[2:1] == 2'b10) && (idx_q == '0)) begin
      a_chunk[0] = ~a_chunk[0];
      b_chunk[0] = ~b_chunk[0];
    end
    chunk_ne   = (a_chunk != b_chunk);
    chunk_lt   = (a_chunk <  b_chunk);
    last_chunk = (idx_q == IW'(N - 1));
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    f3_d      = f3_q;
    target_d  = target_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    diff_d    = diff_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    done_now  = 1'b0;

    if (bus.flush) begin
      // Kill wins over everything, including a coincident response handshake.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            state_d  = CMP;
            rs1_d    = bus.rs1;
            rs2_d    = bus.rs2;
            f3_d     = bus.funct3;
            target_d = bus.pc + bus.imm;
            idx_d    = '0;
            diff_d   = 1'b0;
          end
        end

        CMP: begin
          // The first differing chunk decides the ordering; later chunks
          // cannot change it.
          if (!diff_q && chunk_ne) begin
            diff_d = 1'b1;
            lt_d   = chunk_lt;
            eq_d   = 1'b0;
          end
          if (last_chunk && !diff_q && !chunk_ne) begin
            eq_d = 1'b1;
            lt_d = 1'b0;
          end
`ifdef BRANCH_CMP_EARLY_EXIT_EN
          done_now = chunk_ne || last_chunk;
`else
          done_now = last_chunk;
`endif
          if (done_now) begin
            state_d   = DONE;
            taken_d   = resolve(f3_q, lt_d, eq_d);
            illegal_d = (f3_q[2:1] == 2'b01);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end

        DONE: begin
          if (bus.resp_ready) state_d = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      f3_q      <= '0;
      target_q  <= '0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      diff_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      f3_q      <= f3_d;
      target_q  <= target_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      diff_q    <= diff_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  // Response side depends only on registered state: no req_* -> resp_* path.
  assign bus.req_ready  = (state_q == IDLE) && !bus.flush;
  assign bus.resp_valid = (state_q == DONE);
  assign bus.taken      = taken_q;
  assign bus.target     = target_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_branch_cmp_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_cmp_unit
//   Self-checking bench for branch_cmp_unit (XLEN=32, CHUNK=8).
//   A behavioural model (plain signed/unsigned arithmetic and a cycle counter
//   per transaction) predicts resp_valid, req_ready, taken, target and illegal;
//   a negedge compare process checks the DUT every cycle. Directed cases pin
//   the model with hand-computed literals. Latencies are counted in clock
//   edges after the accepting edge k: resp_valid first seen after edge k+L,
//   i.e. in the cycle that ends at edge k+L+1.
// -----------------------------------------------------------------------------
module tb_branch_cmp_unit;

  localparam int XLEN = 32;
  localparam int NCH  = 4;
`ifdef BRANCH_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int LAT_MSB_DIFF = EARLY ? 1 : NCH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_cmp_unit_if #(.XLEN(XLEN)) bus ();

  branch_cmp_unit #(.XLEN(XLEN), .CHUNK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] f3, output logic tk,
                                output logic il, output int lat);
    logic lt_s, lt_u, eq;
    int   first;
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    eq   = (a == b);
    il   = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000:  tk = eq;
      3'b001:  tk = !eq;
      3'b100:  tk = lt_s;
      3'b101:  tk = !lt_s;
      3'b110:  tk = lt_u;
      3'b111:  tk = !lt_u;
      default: tk = 1'b0;
    endcase
    first = NCH;
    for (int i = NCH - 1; i >= 0; i--)
      if (a[31-8*i -: 8] != b[31-8*i -: 8]) first = i;
    lat = (EARLY && first < NCH) ? first + 1 : NCH;
  endfunction

  logic        m_known = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_post_rst = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 0;
  logic        m_taken = 1'b0;
  logic        m_illegal = 1'b0;
  logic [31:0] m_target = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known    = 1'b1;
      m_busy     = 1'b0;
      m_post_rst = 1'b1;
    end else begin
      m_post_rst = 1'b0;
      if (bus.flush) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (bus.req_valid) begin
          model(bus.rs1, bus.rs2, bus.funct3, m_taken, m_illegal, m_lat);
          m_target = bus.pc + bus.imm;
          m_cnt    = 0;
          m_busy   = 1'b1;
        end
      end else if (m_cnt < m_lat) begin
        m_cnt++;
      end else if (bus.resp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_known) begin
      logic exp_rv;
      exp_rv = m_busy && (m_cnt == m_lat);
      check("resp_valid", 64'(bus.resp_valid), 64'(exp_rv));
      check("req_ready", 64'(bus.req_ready), 64'(!m_busy && !bus.flush));
      if (exp_rv) begin
        check("taken", 64'(bus.taken), 64'(m_taken));
        check("target", 64'(bus.target), 64'(m_target));
        check("illegal", 64'(bus.illegal), 64'(m_illegal));
      end
      if (m_post_rst) begin
        check("rst_taken", 64'(bus.taken), 64'(0));
        check("rst_target", 64'(bus.target), 64'(0));
        check("rst_illegal", 64'(bus.illegal), 64'(0));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic txn(input logic [31:0] a, input logic [31:0] b,
                     input logic [2:0] f3, input logic [31:0] pc,
                     input logic [31:0] imm, input int stall, input int flush_at,
                     input bit rst_done, output logic tk, output logic [31:0] tg,
                     output logic il, output int lat);
    bit seen;
    tk = 1'b0; tg = '0; il = 1'b0; lat = -1;
    @(negedge clk); #1;
    bus.req_valid = 1'b1;
    bus.rs1 = a; bus.rs2 = b; bus.funct3 = f3; bus.pc = pc; bus.imm = imm;
    @(posedge clk); #1;
    // Operands must have been latched; scramble the bus to prove it.
    bus.req_valid = 1'b0;
    bus.rs1 = $urandom; bus.rs2 = $urandom; bus.funct3 = 3'($urandom);
    bus.pc = $urandom; bus.imm = $urandom;
    if (flush_at >= 0) begin
      repeat (flush_at) @(posedge clk);
      #1 bus.flush = 1'b1;
      bus.resp_ready = 1'($urandom);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      bus.resp_ready = 1'b0;
      return;
    end
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!seen) begin
      check("resp_timeout", 64'(0), 64'(1));
      return;
    end
    tk = bus.taken; tg = bus.target; il = bus.illegal;
    if (rst_done) begin
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rstdone_resp_valid", 64'(bus.resp_valid), 64'(0));
      check("rstdone_taken", 64'(bus.taken), 64'(0));
      check("rstdone_target", 64'(bus.target), 64'(0));
      check("rstdone_illegal", 64'(bus.illegal), 64'(0));
      check("rstdone_req_ready", 64'(bus.req_ready), 64'(1));
      return;
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("bp_req_ready", 64'(bus.req_ready), 64'(0));
      check("bp_taken_hold", 64'(bus.taken), 64'(tk));
      check("bp_target_hold", 64'(bus.target), 64'(tg));
    end
    #1 bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        tk, il;
    logic [31:0] tg;
    int          lat;

    bus.req_valid = 1'b0; bus.flush = 1'b0; bus.resp_ready = 1'b0;
    bus.rs1 = '0; bus.rs2 = '0; bus.funct3 = '0; bus.pc = '0; bus.imm = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // BEQ, equal operands: full walk, edge k+4 -> seen in cycle k+5.
    txn(32'h12345678, 32'h12345678, 3'b000, 32'h100, 32'h20, 0, -1, 0, tk, tg, il, lat);
    check("beq_taken", 64'(tk), 64'(1));
    check("beq_target", 64'(tg), 64'(32'h120));
    check("beq_illegal", 64'(il), 64'(0));
    check("beq_lat", 64'(lat), 64'(4));

    // BLT / BLTU on -1 vs 1: MSB chunk differs.
    txn(32'hFFFFFFFF, 32'h00000001, 3'b100, 32'h0, 32'h8, 0, -1, 0, tk, tg, il, lat);
    check("blt_taken", 64'(tk), 64'(1));
    check("blt_lat", 64'(lat), 64'(LAT_MSB_DIFF));
    txn(32'hFFFFFFFF, 32'h00000001, 3'b110, 32'h0, 32'h8, 0, -1, 0, tk, tg, il, lat);
    check("bltu_taken", 64'(tk), 64'(0));
    check("bltu_lat", 64'(lat), 64'(LAT_MSB_DIFF));

    // BGE with wrapping target, held under 3 cycles of backpressure.
    txn(32'h80000000, 32'h7FFFFFFF, 3'b101, 32'hFFFFFFF0, 32'h20, 3, -1, 0, tk, tg, il, lat);
    check("bge_taken", 64'(tk), 64'(0));
    check("bge_target", 64'(tg), 64'(32'h10));

    // BNE issued straight after the handshake.
    txn(32'h1, 32'h2, 3'b001, 32'h40, 32'hFFFFFFFC, 0, -1, 0, tk, tg, il, lat);
    check("bne_taken", 64'(tk), 64'(1));
    check("bne_target", 64'(tg), 64'(32'h3C));
    check("bne_lat", 64'(lat), 64'(4));

    // Illegal funct3: comparison still runs.
    txn(32'h5, 32'h5, 3'b010, 32'h0, 32'h0, 0, -1, 0, tk, tg, il, lat);
    check("ill_illegal", 64'(il), 64'(1));
    check("ill_taken", 64'(tk), 64'(0));
    check("ill_lat", 64'(lat), 64'(4));

    // Flush while comparing chunk 1.
    txn(32'hABCD0000, 32'hABCD0000, 3'b000, 32'h0, 32'h4, 0, 1, 0, tk, tg, il, lat);
    @(negedge clk);
    check("flush_req_ready", 64'(bus.req_ready), 64'(1));
    for (int c = 0; c < 6; c++) begin
      check("flush_no_resp", 64'(bus.resp_valid), 64'(0));
      @(negedge clk);
    end

    // req_valid together with flush is ignored.
    #1 bus.req_valid = 1'b1; bus.flush = 1'b1;
    bus.rs1 = 32'h1; bus.rs2 = 32'h1; bus.funct3 = 3'b000;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("flushreq_no_resp", 64'(bus.resp_valid), 64'(0));
    end

    // Reset while in DONE.
    txn(32'h10, 32'h20, 3'b100, 32'h1000, 32'h10, 0, -1, 1, tk, tg, il, lat);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, b;
      int          fa;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = a;
        2:       b = a ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
        default: b = a ^ 32'h80000000;
      endcase
      fa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
      txn(a, b, 3'($urandom), $urandom, $urandom, $urandom_range(0, 3), fa, 0,
          tk, tg, il, lat);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
